// File: rtl/ex_mem_stage_register_if.sv
// EX/MEM stage bundle: EX-side inputs, stall/flush controls and MEM-side outputs.
// The master modport is the EX/hazard side that drives the stage; the slave
// modport is the pipeline register itself.
// Optional feature macro: EX_MEM_BUBBLE_COUNT_EN adds the BubbleCount output.
// Handshake: there is no valid/ready pair; ID_EX_Valid qualifies the EX-side
// payload on every rising edge, Stall holds the stage and Flush forces a bubble.
interface ex_mem_stage_register_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      Stall;
    logic                      Flush;
    logic                      ID_EX_Valid;
    logic [DATA_WIDTH-1:0]     ALUResult_in;
    logic [DATA_WIDTH-1:0]     WriteData_in;
    logic [REG_ADDR_WIDTH-1:0] RegisterRd_in;
    logic                      RegWrite_in;
    logic                      MemRead_in;
    logic                      MemWrite_in;
    logic                      MemtoReg_in;

    logic                      EX_MEM_Valid;
    logic [DATA_WIDTH-1:0]     EX_MEM_ALUResult;
    logic [DATA_WIDTH-1:0]     EX_MEM_WriteData;
    logic [REG_ADDR_WIDTH-1:0] EX_MEM_RegisterRd;
    logic                      EX_MEM_RegWrite;
    logic                      EX_MEM_MemRead;
    logic                      EX_MEM_MemWrite;
    logic                      EX_MEM_MemtoReg;
`ifdef EX_MEM_BUBBLE_COUNT_EN
    logic [15:0]               BubbleCount;
`endif

    modport master (
        output Stall, Flush, ID_EX_Valid, ALUResult_in, WriteData_in,
               RegisterRd_in, RegWrite_in, MemRead_in, MemWrite_in, MemtoReg_in,
        input  EX_MEM_Valid, EX_MEM_ALUResult, EX_MEM_WriteData,
               EX_MEM_RegisterRd, EX_MEM_RegWrite, EX_MEM_MemRead,
               EX_MEM_MemWrite, EX_MEM_MemtoReg
`ifdef EX_MEM_BUBBLE_COUNT_EN
        , input BubbleCount
`endif
    );

    modport slave (
        input  Stall, Flush, ID_EX_Valid, ALUResult_in, WriteData_in,
               RegisterRd_in, RegWrite_in, MemRead_in, MemWrite_in, MemtoReg_in,
        output EX_MEM_Valid, EX_MEM_ALUResult, EX_MEM_WriteData,
               EX_MEM_RegisterRd, EX_MEM_RegWrite, EX_MEM_MemRead,
               EX_MEM_MemWrite, EX_MEM_MemtoReg
`ifdef EX_MEM_BUBBLE_COUNT_EN
        , output BubbleCount
`endif
    );
endinterface

// File: rtl/ex_mem_stage_register.sv
// EX/MEM pipeline register of the 5-stage MIPS pipeline.
// Captures ALU result, store data, qualified destination register and MEM/WB
// controls. Edge priority: reset > Flush > Stall > load. A non-writing
// instruction always presents Rd=0, so forwarding compares on Rd alone are safe.
// Optional feature macro: EX_MEM_BUBBLE_COUNT_EN adds a saturating 16-bit
// count of bubbles loaded (by Flush, or by ID_EX_Valid=0 on an unstalled edge).
module ex_mem_stage_register #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    ex_mem_stage_register_if.slave bus
);
    logic                      valid_q,     valid_d;
    logic [DATA_WIDTH-1:0]     alu_q,       alu_d;
    logic [DATA_WIDTH-1:0]     wdata_q,     wdata_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q,        rd_d;
    logic                      regwrite_q,  regwrite_d;
    logic                      memread_q,   memread_d;
    logic                      memwrite_q,  memwrite_d;
    logic                      memtoreg_q,  memtoreg_d;

    logic                      load_en;
    logic                      load_bubble;
    logic                      qual_regwrite;

    // Stall freezes everything; Flush wins over Stall and forces a bubble.
    assign load_en       = bus.Flush || !bus.Stall;
    assign load_bubble   = bus.Flush || !bus.ID_EX_Valid;
    assign qual_regwrite = bus.RegWrite_in && (bus.RegisterRd_in != '0);

    // Next-state selection: bubble (all zero) or qualified EX-stage payload.
    always_comb begin
        valid_d    = 1'b0;
        alu_d      = '0;
        wdata_d    = '0;
        rd_d       = '0;
        regwrite_d = 1'b0;
        memread_d  = 1'b0;
        memwrite_d = 1'b0;
        memtoreg_d = 1'b0;
        if (!load_bubble) begin
            valid_d    = 1'b1;
            alu_d      = bus.ALUResult_in;
            wdata_d    = bus.WriteData_in;
            regwrite_d = qual_regwrite;
            rd_d       = qual_regwrite ? bus.RegisterRd_in : '0;
            // A store wins over a load if both are asserted.
            memwrite_d = bus.MemWrite_in;
            memread_d  = bus.MemRead_in && !bus.MemWrite_in;
            memtoreg_d = bus.MemtoReg_in;
        end
    end

    // Stage register: synchronous reset, otherwise load when not held.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            alu_q      <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
        end else if (load_en) begin
            valid_q    <= valid_d;
            alu_q      <= alu_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            memtoreg_q <= memtoreg_d;
        end
    end

    assign bus.EX_MEM_Valid      = valid_q;
    assign bus.EX_MEM_ALUResult  = alu_q;
    assign bus.EX_MEM_WriteData  = wdata_q;
    assign bus.EX_MEM_RegisterRd = rd_q;
    assign bus.EX_MEM_RegWrite   = regwrite_q;
    assign bus.EX_MEM_MemRead    = memread_q;
    assign bus.EX_MEM_MemWrite   = memwrite_q;
    assign bus.EX_MEM_MemtoReg   = memtoreg_q;

`ifdef EX_MEM_BUBBLE_COUNT_EN
    logic [15:0] bubble_cnt_q, bubble_cnt_d;

    // Count bubbles actually loaded; saturate rather than wrap.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (load_en && load_bubble && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end

    // Bubble counter register, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_q <= 16'd0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.BubbleCount = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage_register.sv
// Directed bench for ex_mem_stage_register.
// Optional feature macro: EX_MEM_BUBBLE_COUNT_EN enables the bubble-count tests.
module tb_ex_mem_stage_register;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int OW = 1 + DW + DW + AW + 4;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    ex_mem_stage_register_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) bus ();

    ex_mem_stage_register #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Observed outputs: {Valid, ALUResult, WriteData, Rd, RegWrite, MemRead, MemWrite, MemtoReg}
    logic [OW-1:0] obs;
    assign obs = {bus.EX_MEM_Valid, bus.EX_MEM_ALUResult, bus.EX_MEM_WriteData,
                  bus.EX_MEM_RegisterRd, bus.EX_MEM_RegWrite, bus.EX_MEM_MemRead,
                  bus.EX_MEM_MemWrite, bus.EX_MEM_MemtoReg};

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; outputs are then sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] alu, input logic [DW-1:0] wd,
                         input logic [AW-1:0] rd, input logic rw, input logic mr,
                         input logic mw, input logic m2r);
        bus.ID_EX_Valid   = v;
        bus.ALUResult_in  = alu;
        bus.WriteData_in  = wd;
        bus.RegisterRd_in = rd;
        bus.RegWrite_in   = rw;
        bus.MemRead_in    = mr;
        bus.MemWrite_in   = mw;
        bus.MemtoReg_in   = m2r;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.Stall = 1'b0;
        bus.Flush = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [OW-1:0] exp;
        bus.Stall = 1'b0;
        bus.Flush = 1'b0;
        drive(1'b1, 32'hAAAA_5555, 32'h1234_5678, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
        reset = 1'b1;
        step();
        exp = '0;
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", obs, exp);
        end
`ifdef EX_MEM_BUBBLE_COUNT_EN
        checks++;
        if (bus.BubbleCount !== 16'd0) begin
            errors++;
            $display("FAIL reset_bubblecount: got %0d expected 0", bus.BubbleCount);
        end
`endif
        reset = 1'b0;
        step();
        exp = {1'b1, 32'hAAAA_5555, 32'h1234_5678, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_release_load: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_normal_load();
        logic [OW-1:0] exp;
        drive(1'b1, 32'h0000_1004, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        exp = {1'b1, 32'h0000_1004, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL normal_load: got %h expected %h", obs, exp);
        end
        drive(1'b1, 32'h8000_0040, 32'h0, 5'd31, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        exp = {1'b1, 32'h8000_0040, 32'h0, 5'd31, 1'b1, 1'b1, 1'b0, 1'b1};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL load_instr: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_qualification();
        logic [OW-1:0] exp;
        drive(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        exp = {1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL qual_store_rd9: got %h expected %h", obs, exp);
        end
        drive(1'b1, 32'h0000_0007, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        exp = {1'b1, 32'h0000_0007, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL qual_rd0: got %h expected %h", obs, exp);
        end
        // Both MemRead and MemWrite requested: the store wins.
        drive(1'b1, 32'h0000_0200, 32'h0000_00FF, 5'd4, 1'b0, 1'b1, 1'b1, 1'b1);
        step();
        exp = {1'b1, 32'h0000_0200, 32'h0000_00FF, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL mem_rw_conflict: got %h expected %h", obs, exp);
        end
        // Invalid EX instruction loads a bubble whatever the payload says.
        drive(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        exp = '0;
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL invalid_bubble: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_stall();
        logic [OW-1:0] exp;
        drive(1'b1, 32'h0000_1004, 32'h0000_0055, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        exp = {1'b1, 32'h0000_1004, 32'h0000_0055, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0};
        bus.Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(i[0], 32'h100 + DW'(i), 32'h200 + DW'(i), AW'(i + 10), 1'b1, 1'b1, 1'b0, 1'b1);
            step();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL stall_hold_%0d: got %h expected %h", i, obs, exp);
            end
        end
        bus.Stall = 1'b0;
        drive(1'b1, 32'h0000_3000, 32'h0000_0066, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        exp = {1'b1, 32'h0000_3000, 32'h0000_0066, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL stall_release: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_flush_vs_stall();
        logic [OW-1:0] exp;
        do_reset();
        drive(1'b1, 32'h0000_4444, 32'h0000_0011, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        exp = {1'b1, 32'h0000_4444, 32'h0000_0011, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL flush_preload: got %h expected %h", obs, exp);
        end
        bus.Stall = 1'b1;
        bus.Flush = 1'b1;
        drive(1'b1, 32'h0000_5555, 32'h0000_0022, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        bus.Stall = 1'b0;
        bus.Flush = 1'b0;
        exp = '0;
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL flush_over_stall: got %h expected %h", obs, exp);
        end
`ifdef EX_MEM_BUBBLE_COUNT_EN
        checks++;
        if (bus.BubbleCount !== 16'd1) begin
            errors++;
            $display("FAIL flush_bubblecount: got %0d expected 1", bus.BubbleCount);
        end
`endif
        // Flush alone also bubbles.
        drive(1'b1, 32'h0000_6666, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        bus.Flush = 1'b1;
        step();
        bus.Flush = 1'b0;
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL flush_only: got %h expected %h", obs, exp);
        end
    endtask

`ifdef EX_MEM_BUBBLE_COUNT_EN
    task automatic test_bubble_count();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            // Edges 2 and 5 are stalled; the other five load bubbles.
            bus.Stall = (i == 2 || i == 5);
            drive(1'b0, 32'h0000_0001, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
            step();
        end
        bus.Stall = 1'b0;
        checks++;
        if (bus.BubbleCount !== 16'd5) begin
            errors++;
            $display("FAIL bubble_count: got %0d expected 5", bus.BubbleCount);
        end
        // Valid loads do not count.
        drive(1'b1, 32'h0000_0001, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        checks++;
        if (bus.BubbleCount !== 16'd5) begin
            errors++;
            $display("FAIL bubble_count_valid: got %0d expected 5", bus.BubbleCount);
        end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b1;
        bus.Stall = 1'b0;
        bus.Flush = 1'b0;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_normal_load();
        test_qualification();
        test_stall();
        test_flush_vs_stall();
`ifdef EX_MEM_BUBBLE_COUNT_EN
        test_bubble_count();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
